// File: rtl/alu_serial_addsub_ctrl.sv
// alu_serial_addsub_ctrl: byte-serial add/subtract sequencer with OF/SF/CF/ZF flags
module alu_serial_addsub_ctrl #(
  parameter int WIDTH  = 32,
  parameter int NBYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             OF,
  output logic             SF,
  output logic             CF,
  output logic             ZF
);
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] xr, yr, acc, res;
  logic             subr, carry;
  logic [IW-1:0]    idx;
  logic [7:0]       xb, yb;
  logic [8:0]       sum;
  always_comb begin
    xb  = xr[8*idx +: 8];
    yb  = subr ? ~yr[8*idx +: 8] : yr[8*idx +: 8];
    sum = {1'b0, xb} + {1'b0, yb} + {8'd0, carry};
    res = acc;
    res[8*idx +: 8] = sum[7:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {busy, done, cout, OF, SF, CF, ZF, subr, carry} <= '0;
      {f, xr, yr, acc} <= '0;
      idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            yr    <= y;
            subr  <= sub;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= res;
          carry <= sum[8];
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            f     <= res;
            cout  <= sum[8];
            CF    <= sum[8] ^ subr;
            SF    <= res[WIDTH-1];
            ZF    <= res == '0;
            OF    <= (~xr[WIDTH-1] & ~yb[7] & res[WIDTH-1]) | (xr[WIDTH-1] & yb[7] & ~res[WIDTH-1]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_addsub_ctrl.sv
// tb_alu_serial_addsub_ctrl: cycle model plus directed vectors for the serial add/sub sequencer
module tb_alu_serial_addsub_ctrl;
  localparam int NB = 4;
  logic clk = 0, rst = 1, start = 0, sub = 0;
  logic [31:0] x = 0, y = 0;
  logic busy, done, cout, OF, SF, CF, ZF;
  logic [31:0] f;
  int checks = 0, failures = 0;
  bit armed = 0;

  alu_serial_addsub_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .x(x), .y(y),
    .busy(busy), .done(done), .f(f), .cout(cout), .OF(OF), .SF(SF), .CF(CF), .ZF(ZF)
  );

  always #5 clk = ~clk;

  // {f, cout, OF, SF, CF, ZF} from plain 33-bit arithmetic and sign rules
  function automatic logic [36:0] golden(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [32:0] t;
    logic ov;
    t = s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    if (s) t[32] = ~t[32];
    ov = s ? (a[31] != b[31] && t[31] != a[31]) : (a[31] == b[31] && t[31] != a[31]);
    return {t[31:0], t[32], ov, t[31], t[32] ^ s, t[31:0] == 0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, a, e, $time);
    end
  endtask

  int k = 0;
  logic [36:0] m_out = '0, m_pend = '0;
  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      m_out = '0;
    end else if ((k == 0 || k == NB + 1) && start) begin
      k = 1;
      m_pend = golden(x, y, sub);
    end else if (k >= 1 && k < NB) begin
      k++;
    end else if (k == NB) begin
      k = NB + 1;
      m_out = m_pend;
    end else begin
      k = 0;
    end
  end

  always @(negedge clk)
    if (armed)
      chk("cycle", {25'd0, busy, done, f, cout, OF, SF, CF, ZF},
          {25'd0, k >= 1 && k <= NB, k == NB + 1, m_out});

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
    @(negedge clk);
    start = 1; x = a; y = b; sub = s;
    @(negedge clk);
    start = 0; x = ~a; y = ~b; sub = ~s;
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  initial begin
    @(posedge clk);
    armed = 1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {busy, done, f, cout, OF, SF, CF, ZF}, 0);
    rst = 0;
    chk("model_t1", golden(32'h1, 32'hFFFF_FFFF, 0), {32'h0, 5'b10011});
    chk("model_t3", golden(32'd5, 32'd7, 1), {32'hFFFF_FFFE, 5'b00110});
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 0, lat);
    chk("t1_latency", lat, 5);
    chk("t1_out", {f, cout, OF, SF, CF, ZF}, {32'h0, 5'b10011});
    run_op(32'h7FFF_FFFF, 32'h1, 0, lat);
    chk("t2_out", {f, cout, OF, SF, CF, ZF}, {32'h8000_0000, 5'b01100});
    run_op(32'd5, 32'd7, 1, lat);
    chk("t3_out", {f, cout, OF, SF, CF, ZF}, {32'hFFFF_FFFE, 5'b00110});
    run_op(32'h8000_0000, 32'h1, 1, lat);
    chk("t4_out", {f, cout, OF, SF, CF, ZF}, {32'h7FFF_FFFF, 5'b11000});
    // abort: ignored second start, then reset mid-operation
    @(negedge clk);
    start = 1; x = 3; y = 4; sub = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; x = 99; y = 5;
    @(negedge clk);
    start = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_clear", {busy, done, f, cout, OF, SF, CF, ZF}, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", {done, f}, 0);
    run_op(32'd3, 32'd4, 0, lat);
    chk("after_abort_latency", lat, 5);
    chk("after_abort_f", f, 32'd7);
    // back-to-back: B launched in A's done cycle
    run_op(32'd10, 32'd20, 0, lat);
    chk("a_f", {done, f}, {1'b1, 32'd30});
    start = 1; x = 10; y = 20; sub = 1;
    @(negedge clk);
    start = 0; x = 0; y = 0; sub = 0;
    chk("b_busy_hold", {busy, f}, {1'b1, 32'd30});
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("b_latency", lat, 5);
    chk("b_out", {f, cout, OF, SF, CF, ZF}, {32'hFFFF_FFF6, 5'b00110});
    repeat (3) @(negedge clk);
    chk("b_hold", f, 32'hFFFF_FFF6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
